// File: rtl/down_scale_pkg.sv
// Shared definitions for the down-scaling front end (down_scale_con and
// down_scale_PU): default image geometry, block size, averaging constants
// and the controller state encoding.
package down_scale_pkg;

    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;
    localparam int BLOCK_ROWS     = 15;

    // Pixel width of the grayscale stream.
    localparam int DATA_W = 8;

    // down_scale_PU averages 20 columns x 15 rows = 300 pixels.
    // 218 / 65536 approximates 1/300 for the multiply-and-shift divide.
    localparam int COLS_PER_OUT = 20;
    localparam int DIV_CONST    = 218;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/down_scale_line_buf.sv
// One line of pixel storage: simple dual-port RAM with a single write port
// and a single registered read port, shaped so synthesis maps it to block RAM.
// The array itself is never reset; only the read data register is cleared.
module down_scale_line_buf
    import down_scale_pkg::*;
#(
    parameter int DEPTH  = IMG_WIDTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store one pixel per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: one-cycle synchronous read; holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/down_scale_con.sv
// Line-buffer controller feeding down_scale_PU. Rows 0..13 of each 15-row
// block are stored in 14 line buffers; during row 14 every incoming pixel
// produces one 15-pixel column vector one cycle later.
// Optional feature: define DOWN_SCALE_CON_SOF_EN to add the pix_sof input,
// which realigns all counters to the start of a frame.
module down_scale_con #(
    parameter int IMG_WIDTH  = down_scale_pkg::IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = down_scale_pkg::IMG_HEIGHT_DEF,
    parameter int BLOCK_ROWS = down_scale_pkg::BLOCK_ROWS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
`ifdef DOWN_SCALE_CON_SOF_EN
    input  logic       pix_sof,
`endif
    output logic       down_scale_con_valid,
    output logic [7:0] down_scale_con_line_0,
    output logic [7:0] down_scale_con_line_1,
    output logic [7:0] down_scale_con_line_2,
    output logic [7:0] down_scale_con_line_3,
    output logic [7:0] down_scale_con_line_4,
    output logic [7:0] down_scale_con_line_5,
    output logic [7:0] down_scale_con_line_6,
    output logic [7:0] down_scale_con_line_7,
    output logic [7:0] down_scale_con_line_8,
    output logic [7:0] down_scale_con_line_9,
    output logic [7:0] down_scale_con_line_10,
    output logic [7:0] down_scale_con_line_11,
    output logic [7:0] down_scale_con_line_12,
    output logic [7:0] down_scale_con_line_13,
    output logic [7:0] down_scale_con_line_14,
    output logic       frame_done
);

    import down_scale_pkg::*;

    localparam int NUM_BUFS = BLOCK_ROWS - 1;
    localparam int NUM_BLKS = IMG_HEIGHT / BLOCK_ROWS;
    localparam int COL_W    = $clog2(IMG_WIDTH);
    localparam int ROW_W    = $clog2(BLOCK_ROWS);
    localparam int BLK_W    = (NUM_BLKS > 1) ? $clog2(NUM_BLKS) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BLOCK_ROWS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLKS - 1);

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col_cnt, col_nxt;
    logic [ROW_W-1:0]  row_cnt, row_nxt;
    logic [BLK_W-1:0]  blk_cnt, blk_nxt;

    // Position of the current pixel after any start-of-frame realignment.
    logic              sof_hit;
    state_t            eff_state;
    logic [COL_W-1:0]  eff_col;
    logic [ROW_W-1:0]  eff_row;
    logic [BLK_W-1:0]  eff_blk;

    logic              emit_fire;
    logic              last_vec;
    logic [NUM_BUFS-1:0] buf_wr_en;
    logic [DATA_W-1:0] buf_rd [NUM_BUFS];

    logic              vld_p0;
    logic              frame_done_p0;
    logic [DATA_W-1:0] line14_p0;

`ifdef DOWN_SCALE_CON_SOF_EN
    assign sof_hit = pix_valid & pix_sof;
`else
    assign sof_hit = 1'b0;
`endif

    // Next-state and counter update; SOF makes the pixel count as row 0, col 0.
    always_comb begin
        eff_state = sof_hit ? FILL : state;
        eff_col   = sof_hit ? '0 : col_cnt;
        eff_row   = sof_hit ? '0 : row_cnt;
        eff_blk   = sof_hit ? '0 : blk_cnt;

        col_nxt   = col_cnt;
        row_nxt   = row_cnt;
        blk_nxt   = blk_cnt;

        if (pix_valid) begin
            col_nxt = eff_col + 1'b1;
            row_nxt = eff_row;
            blk_nxt = eff_blk;
            if (eff_col == COL_LAST) begin
                col_nxt = '0;
                if (eff_row == ROW_LAST) begin
                    row_nxt = '0;
                    blk_nxt = (eff_blk == BLK_LAST) ? '0 : eff_blk + 1'b1;
                end else begin
                    row_nxt = eff_row + 1'b1;
                end
            end
        end

        state_nxt = (row_nxt == ROW_LAST) ? EMIT : FILL;

        emit_fire = pix_valid && (eff_state == EMIT);
        last_vec  = emit_fire && (eff_col == COL_LAST) && (eff_blk == BLK_LAST);

        for (int i = 0; i < NUM_BUFS; i++) begin
            buf_wr_en[i] = pix_valid && (eff_state == FILL) && (eff_row == ROW_W'(i));
        end
    end

    // State and position counters; only pixels with pix_valid advance them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FILL;
            col_cnt <= '0;
            row_cnt <= '0;
            blk_cnt <= '0;
        end else begin
            state   <= state_nxt;
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
            blk_cnt <= blk_nxt;
        end
    end

    // Writes and reads never share a buffer in one cycle: writes occur only
    // in FILL, reads only in EMIT.
    for (genvar i = 0; i < NUM_BUFS; i++) begin : g_buf
        down_scale_line_buf #(
            .DEPTH  (IMG_WIDTH),
            .ADDR_W (COL_W)
        ) u_line_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (buf_wr_en[i]),
            .wr_addr (eff_col),
            .wr_data (pix_data),
            .rd_en   (emit_fire),
            .rd_addr (eff_col),
            .rd_data (buf_rd[i])
        );
    end

    // Output stage p0: the live row-14 pixel is registered to line up with
    // the one-cycle buffer read; valid and frame_done travel with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0        <= 1'b0;
            frame_done_p0 <= 1'b0;
            line14_p0     <= '0;
        end else begin
            vld_p0        <= emit_fire;
            frame_done_p0 <= last_vec;
            if (emit_fire) begin
                line14_p0 <= pix_data;
            end
        end
    end

    assign down_scale_con_valid   = vld_p0;
    assign frame_done             = frame_done_p0;
    assign down_scale_con_line_0  = buf_rd[0];
    assign down_scale_con_line_1  = buf_rd[1];
    assign down_scale_con_line_2  = buf_rd[2];
    assign down_scale_con_line_3  = buf_rd[3];
    assign down_scale_con_line_4  = buf_rd[4];
    assign down_scale_con_line_5  = buf_rd[5];
    assign down_scale_con_line_6  = buf_rd[6];
    assign down_scale_con_line_7  = buf_rd[7];
    assign down_scale_con_line_8  = buf_rd[8];
    assign down_scale_con_line_9  = buf_rd[9];
    assign down_scale_con_line_10 = buf_rd[10];
    assign down_scale_con_line_11 = buf_rd[11];
    assign down_scale_con_line_12 = buf_rd[12];
    assign down_scale_con_line_13 = buf_rd[13];
    assign down_scale_con_line_14 = line14_p0;

endmodule

// File: tb/tb_down_scale_con.sv
// Testbench for down_scale_con on a reduced 40x45 image (3 blocks).
// A frame-position model predicts every cycle's outputs from the pixel stream.
module tb_down_scale_con;

    localparam int W    = 40;
    localparam int H    = 45;
    localparam int NBLK = H / 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       sof;
    logic       vld;
    logic       fd;
    logic [7:0] ln [15];

    always #5 clk = ~clk;

    down_scale_con #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .BLOCK_ROWS (15)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .pix_valid              (pix_valid),
        .pix_data               (pix_data),
`ifdef DOWN_SCALE_CON_SOF_EN
        .pix_sof                (sof),
`endif
        .down_scale_con_valid   (vld),
        .down_scale_con_line_0  (ln[0]),
        .down_scale_con_line_1  (ln[1]),
        .down_scale_con_line_2  (ln[2]),
        .down_scale_con_line_3  (ln[3]),
        .down_scale_con_line_4  (ln[4]),
        .down_scale_con_line_5  (ln[5]),
        .down_scale_con_line_6  (ln[6]),
        .down_scale_con_line_7  (ln[7]),
        .down_scale_con_line_8  (ln[8]),
        .down_scale_con_line_9  (ln[9]),
        .down_scale_con_line_10 (ln[10]),
        .down_scale_con_line_11 (ln[11]),
        .down_scale_con_line_12 (ln[12]),
        .down_scale_con_line_13 (ln[13]),
        .down_scale_con_line_14 (ln[14]),
        .frame_done             (fd)
    );

    int n_checks = 0;
    int n_errors = 0;
    int vec_cnt  = 0;
    int fd_cnt   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the frame is a flat pixel index; rows 0..13 of the
    // current block are kept in an image array, row 14 forms the vectors.
    logic [7:0]   img [14][W];
    int           pos;
    logic         exp_vld;
    logic         exp_fd;
    logic [119:0] exp_lines;

    always @(posedge clk) begin
        int p, r, c;
        logic [119:0] v;
        if (!rst_n) begin
            pos       <= 0;
            exp_vld   <= 1'b0;
            exp_fd    <= 1'b0;
            exp_lines <= '0;
        end else begin
            exp_vld <= 1'b0;
            exp_fd  <= 1'b0;
            if (pix_valid) begin
                p = sof ? 0 : pos;
                r = (p / W) % 15;
                c = p % W;
                if (r == 14) begin
                    for (int k = 0; k < 14; k++) v[k*8 +: 8] = img[k][c];
                    v[119:112] = pix_data;
                    exp_lines <= v;
                    exp_vld   <= 1'b1;
                    exp_fd    <= (p == W*H - 1);
                end else begin
                    img[r][c] <= pix_data;
                end
                pos <= (p + 1) % (W * H);
            end
        end
    end

    logic [119:0] obs_lines;
    always_comb begin
        obs_lines = '0;
        for (int k = 0; k < 15; k++) obs_lines[k*8 +: 8] = ln[k];
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 128'(vld), 128'(exp_vld));
            check("lines", 128'(obs_lines), 128'(exp_lines));
            check("frame_done", 128'(fd), 128'(exp_fd));
            if (vld) vec_cnt++;
            if (fd)  fd_cnt++;
        end
    end

    task automatic send(input logic v, input logic [7:0] d, input logic s);
        pix_valid = v;
        pix_data  = d;
        sof       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic send_rand(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) send(1'b0, 8'($urandom), 1'b0);
            send(1'b1, 8'($urandom), 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        sof       = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(2);
        check("reset_valid", 128'(vld), 128'(0));
        check("reset_lines", 128'(obs_lines), 128'(0));
        check("reset_frame_done", 128'(fd), 128'(0));
        rst_n = 1'b1;

        // Ramp block: pixel = (row*16 + col) mod 256.
        v0 = vec_cnt;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < W; c++) send(1'b1, 8'((r*16 + c) % 256), 1'b0);
        idle(3);
        check("ramp_vec_count", 128'(vec_cnt - v0), 128'(W));

        // Full frame of random pixels with random gaps.
        do_reset();
        v0 = vec_cnt; f0 = fd_cnt;
        send_rand(W*H, 30);
        idle(3);
        check("frame_vec_count", 128'(vec_cnt - v0), 128'(W*NBLK));
        check("frame_done_count", 128'(fd_cnt - f0), 128'(1));

        // Valid toggling 1-0-1-0 through row 14.
        do_reset();
        v0 = vec_cnt;
        send_rand(14*W, 0);
        for (int c = 0; c < W; c++) begin
            send(1'b1, 8'($urandom), 1'b0);
            send(1'b0, 8'($urandom), 1'b0);
        end
        idle(3);
        check("gap_vec_count", 128'(vec_cnt - v0), 128'(W));

        // Reset for one cycle in the middle of row 14, then a clean block.
        do_reset();
        send_rand(14*W + W/2, 0);
        rst_n = 1'b0;
        send(1'b1, 8'($urandom), 1'b0);
        rst_n = 1'b1;
        check("midreset_valid", 128'(vld), 128'(0));
        check("midreset_lines", 128'(obs_lines), 128'(0));
        v0 = vec_cnt;
        send_rand(15*W, 10);
        idle(3);
        check("midreset_vec_count", 128'(vec_cnt - v0), 128'(W));

`ifdef DOWN_SCALE_CON_SOF_EN
        // SOF at row 7 of the second block restarts the frame.
        do_reset();
        send_rand(15*W + 7*W + 5, 10);
        v0 = vec_cnt; f0 = fd_cnt;
        send(1'b1, 8'($urandom), 1'b1);
        send_rand(15*W - 1, 10);
        idle(3);
        check("sof_block_vec_count", 128'(vec_cnt - v0), 128'(W));
        check("sof_no_frame_done", 128'(fd_cnt - f0), 128'(0));
        send_rand(2*15*W, 10);
        idle(3);
        check("sof_frame_done_count", 128'(fd_cnt - f0), 128'(1));
`endif

        // Two back-to-back frames without idle cycles.
        do_reset();
        v0 = vec_cnt; f0 = fd_cnt;
        send_rand(2*W*H, 0);
        idle(3);
        check("b2b_vec_count", 128'(vec_cnt - v0), 128'(2*W*NBLK));
        check("b2b_frame_done_count", 128'(fd_cnt - f0), 128'(2));

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
